// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   state_t    - scanner FSM states
//   key_code   - [row][col] position to 4-bit key code
//   onehot_low - active-low single-column drive pattern
//   KEY_NONE   - row pattern with no key pulling a line low
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    localparam logic [3:0] KEY_NONE = 4'b1111;

    // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D  (* = E, # = F)
    function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] onehot_low(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the key-event outputs.
//   scan_en    - enable scanning (0 releases all columns)
//   row_in     - raw active-low keypad rows (asynchronous)
//   col_out    - active-low column drive
//   user_digit - code of the last accepted key
//   user_latch - one-cycle strobe with each new user_digit
//   key_held   - high from accept until debounced release
interface keypad_scanner_if;
    logic       scan_en;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] user_digit;
    logic       user_latch;
    logic       key_held;

    modport master (
        output scan_en, row_in,
        input  col_out, user_digit, user_latch, key_held
    );

    modport slave (
        input  scan_en, row_in,
        output col_out, user_digit, user_latch, key_held
    );
endinterface

// File: rtl/keypad_scanner_sync.sv
// sync_2ff: two-flop synchroniser with a reset value on both stages.
//   clk, reset - system clock, synchronous active-high reset
//   i_d        - asynchronous input bus
//   o_q        - synchronised output bus
module sync_2ff #(
    parameter int   W       = 4,
    parameter logic RST_VAL = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= {W{RST_VAL}};
            r_sync <= {W{RST_VAL}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces press and release,
// and emits one user_digit/user_latch event per physical press.
//   clk, reset - system clock, synchronous active-high reset
//   kp         - keypad_scanner_if slave (scan_en, row_in, col_out,
//                user_digit, user_latch, key_held)
//
//   state    | meaning
//   SCAN     | drive one column for SCAN_DIV cycles, look for a single low row
//   DEBOUNCE | same column held, rows must match the captured pattern
//   PRESSED  | key accepted, wait for DEBOUNCE_CYCLES of all rows high
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input logic            clk,
    input logic            reset,
    keypad_scanner_if.slave kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_col, w_col_nxt;
    logic [DW-1:0] r_dwell, w_dwell_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_row, w_row_nxt;
    logic [3:0]    r_pat, w_pat_nxt;
    logic [3:0]    r_digit, w_digit_nxt;
    logic          r_latch, w_latch_nxt;
    logic          r_idle, w_idle_nxt;

    logic [3:0]    w_rows_s;
    logic          w_one_low;
    logic [1:0]    w_low_idx;

    sync_2ff #(.W(4), .RST_VAL(1'b1)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (kp.row_in),
        .o_q   (w_rows_s)
    );

    // Exactly one row low; two or more keys in a column are treated as no key.
    always_comb begin
        w_one_low = 1'b1;
        w_low_idx = 2'd0;
        case (w_rows_s)
            4'b1110: w_low_idx = 2'd0;
            4'b1101: w_low_idx = 2'd1;
            4'b1011: w_low_idx = 2'd2;
            4'b0111: w_low_idx = 2'd3;
            default: w_one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SCAN;
            r_col   <= 2'd0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_row   <= 2'd0;
            r_pat   <= KEY_NONE;
            r_digit <= 4'h0;
            r_latch <= 1'b0;
            r_idle  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_dwell <= w_dwell_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_pat   <= w_pat_nxt;
            r_digit <= w_digit_nxt;
            r_latch <= w_latch_nxt;
            r_idle  <= w_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_dwell_nxt = r_dwell;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_pat_nxt   = r_pat;
        w_digit_nxt = r_digit;
        w_latch_nxt = 1'b0;
        w_idle_nxt  = 1'b0;

        if (!kp.scan_en) begin
            w_state_nxt = SCAN;
            w_col_nxt   = 2'd0;
            w_dwell_nxt = '0;
            w_cnt_nxt   = '0;
            w_idle_nxt  = 1'b1;
        end else if (r_idle) begin
            // Columns were released this cycle; hold the dwell at zero so
            // column 0 gets its full dwell once it is actually driven.
            w_dwell_nxt = '0;
        end else begin
            case (r_state)
                SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        w_dwell_nxt = '0;
                        if (w_one_low) begin
                            w_row_nxt   = w_low_idx;
                            w_pat_nxt   = w_rows_s;
                            w_cnt_nxt   = '0;
                            w_state_nxt = DEBOUNCE;
                        end else begin
                            w_col_nxt = r_col + 2'd1;
                        end
                    end else begin
                        w_dwell_nxt = r_dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_rows_s != r_pat) begin
                        w_state_nxt = SCAN;
                        w_col_nxt   = r_col + 2'd1;
                        w_dwell_nxt = '0;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_latch_nxt = 1'b1;
                        w_digit_nxt = key_code(r_row, r_col);
                        w_cnt_nxt   = '0;
                        w_state_nxt = PRESSED;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_rows_s == KEY_NONE) begin
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = SCAN;
                            w_cnt_nxt   = '0;
                            w_dwell_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: w_state_nxt = SCAN;
            endcase
        end
    end

    assign kp.col_out    = r_idle ? KEY_NONE : onehot_low(r_col);
    assign kp.user_digit = r_digit;
    assign kp.user_latch = r_latch;
    assign kp.key_held   = (r_state == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4,
// DEBOUNCE_CYCLES=8. A small keypad model turns the pressed-key matrix and
// col_out into row_in; expected values are hand-derived from the key map.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pressed;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_strobe = 0;
    int          n_double = 0;
    int          n_col_bad = 0;
    logic        prev_latch = 1'b0;
    int          base;

    always #5 clk = ~clk;

    keypad_scanner_if kp_if ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if)
    );

    // pressed[r*4+c] shorts row r to column c.
    function automatic logic [3:0] rows_of(input logic [15:0] keys, input logic [3:0] cols);
        logic [3:0] rows;
        for (int r = 0; r < 4; r++)
            rows[r] = ~|(keys[r*4 +: 4] & ~cols);
        return rows;
    endfunction

    assign kp_if.row_in = rows_of(pressed, kp_if.col_out);

    always @(negedge clk) begin
        if (!reset) begin
            if (kp_if.user_latch) n_strobe++;
            if (kp_if.user_latch && prev_latch) n_double++;
            if ($countones(~kp_if.col_out) > 1) n_col_bad++;
            prev_latch = kp_if.user_latch;
        end else begin
            prev_latch = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int n = 0;
        while (!kp_if.user_latch && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_strobe"}, 32'(kp_if.user_latch), 32'd1);
    endtask

    task automatic wait_released(input string tag, input int budget);
        int n = 0;
        while (kp_if.key_held && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_release"}, 32'(kp_if.key_held), 32'd0);
    endtask

    // Stops on the first cycle a given column becomes driven.
    task automatic wait_col_fresh(input string tag, input logic [3:0] col, input int budget);
        logic [3:0] prev;
        logic       found = 1'b0;
        prev = kp_if.col_out;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if (kp_if.col_out == col && prev != col) found = 1'b1;
            prev = kp_if.col_out;
        end
        check({tag, "_col_found"}, 32'(found), 32'd1);
    endtask

    initial begin
        reset         = 1'b1;
        kp_if.scan_en = 1'b1;
        pressed       = '0;
        tick(3);
        check("rst_col_out", 32'(kp_if.col_out), 32'hE);
        check("rst_digit",   32'(kp_if.user_digit), 32'h0);
        check("rst_latch",   32'(kp_if.user_latch), 32'd0);
        check("rst_held",    32'(kp_if.key_held), 32'd0);
        reset = 1'b0;

        // Key '6' at row1/col2, held about 100 cycles.
        base = n_strobe;
        pressed[1*4+2] = 1'b1;
        wait_strobe("k6", 200);
        check("k6_digit", 32'(kp_if.user_digit), 32'h6);
        check("k6_col",   32'(kp_if.col_out), 32'hB);
        check("k6_held",  32'(kp_if.key_held), 32'd1);
        tick(80);
        check("k6_count", 32'(n_strobe - base), 32'd1);
        check("k6_held_long", 32'(kp_if.key_held), 32'd1);
        pressed = '0;
        tick(9);
        check("k6_held_before_rel", 32'(kp_if.key_held), 32'd1);
        tick(1);
        check("k6_held_after_rel", 32'(kp_if.key_held), 32'd0);
        tick(10);

        // Key '*' bouncing every 3 cycles for 30 cycles, then stable.
        base = n_strobe;
        for (int i = 0; i < 10; i++) begin
            pressed[3*4+0] = ~pressed[3*4+0];
            tick(3);
        end
        check("star_bounce_none", 32'(n_strobe - base), 32'd0);
        pressed[3*4+0] = 1'b1;
        wait_strobe("star", 200);
        check("star_digit", 32'(kp_if.user_digit), 32'hE);
        tick(20);
        check("star_count", 32'(n_strobe - base), 32'd1);
        pressed = '0;
        wait_released("star", 40);
        tick(10);

        // Keys '2' and '5' together on col1: ignored, scan keeps cycling.
        base = n_strobe;
        pressed[0*4+1] = 1'b1;
        pressed[1*4+1] = 1'b1;
        wait_col_fresh("multi", 4'hE, 40);
        tick(4);
        check("multi_c1", 32'(kp_if.col_out), 32'hD);
        tick(4);
        check("multi_c2", 32'(kp_if.col_out), 32'hB);
        tick(4);
        check("multi_c3", 32'(kp_if.col_out), 32'h7);
        tick(4);
        check("multi_c0", 32'(kp_if.col_out), 32'hE);
        tick(80);
        check("multi_none", 32'(n_strobe - base), 32'd0);
        pressed = '0;
        tick(10);

        // Key '0' held 300 cycles, released 20, pressed again.
        base = n_strobe;
        pressed[3*4+1] = 1'b1;
        wait_strobe("k0a", 200);
        check("k0a_digit", 32'(kp_if.user_digit), 32'h0);
        tick(300);
        pressed = '0;
        tick(20);
        check("k0_gap_held", 32'(kp_if.key_held), 32'd0);
        pressed[3*4+1] = 1'b1;
        wait_strobe("k0b", 200);
        check("k0b_digit", 32'(kp_if.user_digit), 32'h0);
        tick(20);
        check("k0_count", 32'(n_strobe - base), 32'd2);
        pressed = '0;
        wait_released("k0", 40);
        tick(10);

        // Key 'D': scan_en dropped on the third DEBOUNCE cycle.
        base = n_strobe;
        wait_col_fresh("kd", 4'h7, 40);
        pressed[3*4+3] = 1'b1;
        tick(6);
        kp_if.scan_en = 1'b0;
        tick(1);
        check("kd_idle_col", 32'(kp_if.col_out), 32'hF);
        check("kd_idle_held", 32'(kp_if.key_held), 32'd0);
        tick(10);
        check("kd_idle_col2", 32'(kp_if.col_out), 32'hF);
        check("kd_idle_none", 32'(n_strobe - base), 32'd0);
        kp_if.scan_en = 1'b1;
        tick(1);
        check("kd_resume_col", 32'(kp_if.col_out), 32'hE);
        wait_strobe("kd", 200);
        check("kd_digit", 32'(kp_if.user_digit), 32'hD);
        tick(20);
        check("kd_count", 32'(n_strobe - base), 32'd1);
        pressed = '0;
        wait_released("kd", 40);
        tick(10);

        // Key '9' accepted, then reset while still pressed.
        pressed[2*4+2] = 1'b1;
        wait_strobe("k9a", 200);
        check("k9a_digit", 32'(kp_if.user_digit), 32'h9);
        tick(20);
        reset = 1'b1;
        tick(1);
        check("k9_rst_col",   32'(kp_if.col_out), 32'hE);
        check("k9_rst_digit", 32'(kp_if.user_digit), 32'h0);
        check("k9_rst_latch", 32'(kp_if.user_latch), 32'd0);
        check("k9_rst_held",  32'(kp_if.key_held), 32'd0);
        tick(1);
        reset = 1'b0;
        base = n_strobe;
        wait_strobe("k9b", 200);
        check("k9b_digit", 32'(kp_if.user_digit), 32'h9);
        tick(20);
        check("k9_count", 32'(n_strobe - base), 32'd1);
        pressed = '0;
        wait_released("k9", 40);

        check("latch_double", 32'(n_double), 32'd0);
        check("col_onehot", 32'(n_col_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
